// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter sequencer with BOOT/RUN/HALT control.
// Handles trap entry/return, redirects, halt/resume, stalls and sequential
// fetch, and emits a one-cycle registered flush pulse for every taken
// control-flow change.
// Optional feature: define PC_SEQ_MISALIGN_CHK_EN to turn a redirect whose
// target is not word aligned into a trap, with a misalign_o pulse. Without
// the macro, redirect targets are word-aligned by clearing bits [1:0], and
// misalign_o is tied low.
module pc_sequencer #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR  = DATA_WIDTH'(32'h0000_0100)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  redirect_valid_i,
  input  logic [DATA_WIDTH-1:0] redirect_target_i,
  input  logic                  trap_i,
  input  logic                  mret_i,
  input  logic                  halt_i,
  input  logic                  resume_i,
  input  logic                  imem_ack_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic [DATA_WIDTH-1:0] epc_o,
  output logic                  flush_o,
  output logic [1:0]            state_o,
  output logic                  misalign_o
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALT   = 2'b10,
    ST_UNUSED = 2'b11
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] w_pc_nxt;
  logic [DATA_WIDTH-1:0] r_epc;
  logic [DATA_WIDTH-1:0] w_epc_nxt;
  logic                  r_flush;
  logic                  w_flush_nxt;
  logic [DATA_WIDTH-1:0] w_pc_plus4;
  logic [DATA_WIDTH-1:0] w_redir_tgt;
  logic                  w_misaligned;

  // Sequential address; natural overflow of the adder gives the wrap to 0.
  assign w_pc_plus4 = r_pc + DATA_WIDTH'(4);

`ifdef PC_SEQ_MISALIGN_CHK_EN
  // Target passes through untouched; low bits decide whether it traps.
  assign w_redir_tgt  = redirect_target_i;
  assign w_misaligned = |redirect_target_i[1:0];
`else
  // Without checking, the target is silently word-aligned.
  assign w_redir_tgt  = redirect_target_i & ~DATA_WIDTH'(3);
  assign w_misaligned = 1'b0;
`endif

  // Next-state / next-pc selection. Trap wins in every state; in RUN the
  // remaining requests are prioritised mret > redirect > halt > stall > ack.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_epc_nxt   = r_epc;
    w_flush_nxt = 1'b0;
    if (trap_i) begin
      w_pc_nxt    = TRAP_VECTOR;
      w_epc_nxt   = r_pc;
      w_flush_nxt = 1'b1;
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_BOOT: begin
          w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (mret_i) begin
            w_pc_nxt    = r_epc;
            w_flush_nxt = 1'b1;
          end else if (redirect_valid_i) begin
            w_flush_nxt = 1'b1;
            if (w_misaligned) begin
              // Misaligned target is handled exactly like a trap.
              w_pc_nxt  = TRAP_VECTOR;
              w_epc_nxt = r_pc;
            end else begin
              w_pc_nxt  = w_redir_tgt;
            end
          end else if (halt_i) begin
            w_state_nxt = ST_HALT;
          end else if (stall_i) begin
            w_pc_nxt    = r_pc;
          end else if (imem_ack_i) begin
            w_pc_nxt    = w_pc_plus4;
          end
        end
        ST_HALT: begin
          // Only resume (or trap, above) leaves HALT; everything else ignored.
          if (resume_i) w_state_nxt = ST_RUN;
        end
        default: begin
          w_state_nxt = ST_BOOT;
        end
      endcase
    end
  end

  // State, PC, EPC and flush registers; reset drops any pending event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_VECTOR;
      r_epc   <= '0;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_epc   <= w_epc_nxt;
      r_flush <= w_flush_nxt;
    end
  end

`ifdef PC_SEQ_MISALIGN_CHK_EN
  logic r_misalign;
  logic w_misalign_take;

  // A misaligned redirect is only taken in RUN when nothing outranks it.
  assign w_misalign_take = (r_state == ST_RUN) & ~trap_i & ~mret_i &
                           redirect_valid_i & w_misaligned;

  // Misalign pulse registered so it lines up with the flush pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_misalign <= 1'b0;
    else      r_misalign <= w_misalign_take;
  end

  assign misalign_o = r_misalign;
`else
  assign misalign_o = 1'b0;
`endif

  assign imem_req_o  = (r_state == ST_RUN);
  assign imem_addr_o = r_pc;
  assign pc_o        = r_pc;
  assign pc_plus4_o  = w_pc_plus4;
  assign epc_o       = r_epc;
  assign flush_o     = r_flush;
  assign state_o     = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer (default parameters).
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        stall_i, redirect_valid_i, trap_i, mret_i, halt_i, resume_i, imem_ack_i;
  logic [31:0] redirect_target_i;
  logic        imem_req_o, flush_o, misalign_o;
  logic [31:0] imem_addr_o, pc_o, pc_plus4_o, epc_o;
  logic [1:0]  state_o;

  int total = 0;
  int bad   = 0;

`ifdef PC_SEQ_MISALIGN_CHK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .redirect_valid_i(redirect_valid_i), .redirect_target_i(redirect_target_i),
    .trap_i(trap_i), .mret_i(mret_i), .halt_i(halt_i), .resume_i(resume_i),
    .imem_ack_i(imem_ack_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .epc_o(epc_o), .flush_o(flush_o),
    .state_o(state_o), .misalign_o(misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall, redir;
    logic [31:0] tgt;
    logic        trap, mret, halt, resume, ack;
    logic [31:0] pc, epc;
    logic [1:0]  st;
    logic        flush, mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic stall, input logic redir, input logic [31:0] tgt,
                              input logic trap, input logic mret, input logic halt,
                              input logic resume, input logic ack,
                              input logic [31:0] pc, input logic [31:0] epc,
                              input logic [1:0] st, input logic flush, input logic mis);
    vec_t v;
    v.stall = stall; v.redir = redir; v.tgt = tgt; v.trap = trap; v.mret = mret;
    v.halt = halt; v.resume = resume; v.ack = ack; v.pc = pc; v.epc = epc;
    v.st = st; v.flush = flush; v.mis = mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Full output check against expected pc/epc/state/flush/misalign.
  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] epc,
                         input logic [1:0] st, input logic flush, input logic mis);
    chk({tag, ".pc"},    pc_o, pc);
    chk({tag, ".addr"},  imem_addr_o, pc);
    chk({tag, ".plus4"}, pc_plus4_o, pc + 32'd4);
    chk({tag, ".epc"},   epc_o, epc);
    chk({tag, ".state"}, {30'd0, state_o}, {30'd0, st});
    chk({tag, ".req"},   {31'd0, imem_req_o}, {31'd0, (st == 2'b01)});
    chk({tag, ".flush"}, {31'd0, flush_o}, {31'd0, flush});
    chk({tag, ".mis"},   {31'd0, misalign_o}, {31'd0, mis});
  endtask

  task automatic drive_idle();
    stall_i = 0; redirect_valid_i = 0; redirect_target_i = '0; trap_i = 0;
    mret_i = 0; halt_i = 0; resume_i = 0; imem_ack_i = 0;
  endtask

  initial begin
    //            st rd tgt           tp mr hl rs ak  pc            epc           st    fl mis
    vecs.push_back(mk(0,0,32'h0,       0,0,0,0,1, 32'h0,        32'h0,        2'b01,0,0)); // BOOT->RUN
    vecs.push_back(mk(0,0,32'h0,       0,0,0,0,1, 32'h4,        32'h0,        2'b01,0,0));
    vecs.push_back(mk(0,0,32'h0,       0,0,0,0,1, 32'h8,        32'h0,        2'b01,0,0));
    vecs.push_back(mk(0,0,32'h0,       0,0,0,0,1, 32'hC,        32'h0,        2'b01,0,0));
    vecs.push_back(mk(0,1,32'h40,      0,0,0,0,1, 32'h40,       32'h0,        2'b01,1,0)); // redirect
    vecs.push_back(mk(0,1,32'h80,      1,1,0,0,1, 32'h100,      32'h40,       2'b01,1,0)); // trap wins
    vecs.push_back(mk(0,0,32'h0,       0,0,0,0,0, 32'h100,      32'h40,       2'b01,0,0)); // one pulse
    vecs.push_back(mk(0,0,32'h0,       0,1,0,0,0, 32'h40,       32'h40,       2'b01,1,0)); // mret
    vecs.push_back(mk(0,1,32'h20,      0,0,0,0,0, 32'h20,       32'h40,       2'b01,1,0));
    vecs.push_back(mk(1,0,32'h0,       0,0,0,0,1, 32'h20,       32'h40,       2'b01,0,0)); // stall x3
    vecs.push_back(mk(1,0,32'h0,       0,0,0,0,1, 32'h20,       32'h40,       2'b01,0,0));
    vecs.push_back(mk(1,0,32'h0,       0,0,0,0,1, 32'h20,       32'h40,       2'b01,0,0));
    vecs.push_back(mk(1,1,32'h200,     0,0,0,0,1, 32'h200,      32'h40,       2'b01,1,0)); // redirect in stall
    vecs.push_back(mk(0,0,32'h0,       0,0,1,0,1, 32'h200,      32'h40,       2'b10,0,0)); // halt
    vecs.push_back(mk(0,1,32'h300,     0,1,0,0,1, 32'h200,      32'h40,       2'b10,0,0)); // ignored
    vecs.push_back(mk(0,0,32'h0,       0,0,0,1,0, 32'h200,      32'h40,       2'b01,0,0)); // resume
    vecs.push_back(mk(0,1,32'h102,     0,0,0,0,0, 32'h100,      MIS ? 32'h200 : 32'h40, 2'b01,1,MIS));
    vecs.push_back(mk(0,0,32'h0,       0,0,0,0,1, 32'h104,      MIS ? 32'h200 : 32'h40, 2'b01,0,0));
    vecs.push_back(mk(0,0,32'h0,       0,0,1,0,0, 32'h104,      MIS ? 32'h200 : 32'h40, 2'b10,0,0));
    vecs.push_back(mk(0,0,32'h0,       1,0,0,0,0, 32'h100,      32'h104,      2'b01,1,0)); // trap in HALT
    vecs.push_back(mk(0,1,32'h10,      0,0,0,0,0, 32'h10,       32'h104,      2'b01,1,0)); // back-to-back
    vecs.push_back(mk(0,1,32'h14,      0,0,0,0,0, 32'h14,       32'h104,      2'b01,1,0));
    vecs.push_back(mk(0,0,32'h0,       0,0,0,0,0, 32'h14,       32'h104,      2'b01,0,0));
    vecs.push_back(mk(0,1,32'hFFFF_FFFC,0,0,0,0,0,32'hFFFF_FFFC,32'h104,      2'b01,1,0));
    vecs.push_back(mk(0,0,32'h0,       0,0,0,0,1, 32'h0,        32'h104,      2'b01,0,0)); // wrap

    // Reset state, held over a clock edge.
    rst = 1'b0;
    drive_idle();
    #12;
    chk_all("reset", 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);

    // Release between edges; still BOOT until the next rising edge.
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_all("boot", 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      stall_i = vecs[i].stall; redirect_valid_i = vecs[i].redir;
      redirect_target_i = vecs[i].tgt; trap_i = vecs[i].trap; mret_i = vecs[i].mret;
      halt_i = vecs[i].halt; resume_i = vecs[i].resume; imem_ack_i = vecs[i].ack;
      @(posedge clk); #1;
      chk_all($sformatf("v%0d", i), vecs[i].pc, vecs[i].epc, vecs[i].st,
              vecs[i].flush, vecs[i].mis);
    end

    // Mid-operation asynchronous reset while a flush pulse is live and stalled.
    drive_idle();
    redirect_valid_i = 1; redirect_target_i = 32'h50;
    @(posedge clk); #1;
    chk_all("pre_rst", 32'h50, 32'h104, 2'b01, 1'b1, 1'b0);
    drive_idle();
    stall_i = 1; imem_ack_i = 1;
    #2;
    rst = 1'b0;
    #1;
    chk_all("async_rst", 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);

    // Release and confirm a clean restart: BOOT -> RUN -> first increment.
    @(negedge clk);
    rst = 1'b1;
    stall_i = 0;
    @(posedge clk); #1;
    chk_all("restart0", 32'h0, 32'h0, 2'b01, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("restart1", 32'h4, 32'h0, 2'b01, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
